// File: rtl/stepper_pkg.sv
// Shared step/direction definitions: filter states and defaults common to the
// stepper driver and its receive-side decoder.
package stepper_pkg;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_LOW,
    ST_RISE,
    ST_HIGH,
    ST_FALL
  } filt_state_t;

  localparam int unsigned FILT_DEFAULT        = 4;
  localparam int unsigned IDLE_CYCLES_DEFAULT = 1000000;
  localparam logic        DIR_POS_DEFAULT     = 1'b1;

endpackage

// File: rtl/step_dir_decoder_if.sv
// Step/direction decoder bus: pin inputs plus the decoded position/timing outputs.
interface step_dir_decoder_if #(
  parameter int unsigned WIDTH = 32
);

  logic                    clear;
  logic                    step_in;
  logic                    dir_in;
  logic signed [WIDTH-1:0] position;
  logic                    step_valid;
  logic                    step_dir;
  logic        [WIDTH-1:0] period;
  logic                    moving;
  logic                    dir_err;

  modport master (
    output clear, step_in, dir_in,
    input  position, step_valid, step_dir, period, moving, dir_err
  );

  modport slave (
    input  clear, step_in, dir_in,
    output position, step_valid, step_dir, period, moving, dir_err
  );

endinterface

// File: rtl/step_dir_decoder_sync_filter.sv
// Two-flop synchronizer followed by a run-length level filter; flags the cycle
// in which a high level is accepted after an accepted low.
module sync_filter
  import stepper_pkg::*;
#(
  parameter int unsigned FILT = FILT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic active
);

  localparam int unsigned RW = $clog2(FILT + 1);

  logic          sync1;
  logic          sync_s;
  logic          last_s;
  logic [RW-1:0] run;
  logic [RW-1:0] run_next;
  logic          full;
  filt_state_t   state;

  always_comb begin
    run_next = run;
    if (sync_s != last_s) begin
      run_next = RW'(1);
    end else if (run != RW'(FILT)) begin
      run_next = run + 1'b1;
    end
  end

  assign full   = (run_next == RW'(FILT));
  assign rise   = (state == ST_RISE) && sync_s && full;
  assign active = (state == ST_RISE) || (state == ST_HIGH);

  // Synchronizer resets high so a line that is high at reset release cannot
  // masquerade as the lows needed to arm.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync_s <= 1'b1;
      last_s <= 1'b1;
      run    <= '0;
      state  <= ST_ARM;
    end else begin
      sync1  <= din;
      sync_s <= sync1;
      last_s <= sync_s;
      run    <= run_next;
      unique case (state)
        ST_ARM:  if (!sync_s && full) state <= ST_LOW;
        ST_LOW:  if (sync_s) state <= ST_RISE;
        ST_RISE: begin
          if (!sync_s)   state <= ST_LOW;
          else if (full) state <= ST_HIGH;
        end
        ST_HIGH: if (!sync_s) state <= ST_FALL;
        ST_FALL: begin
          if (sync_s)    state <= ST_HIGH;
          else if (full) state <= ST_LOW;
        end
        default: state <= ST_ARM;
      endcase
    end
  end

endmodule

// File: rtl/step_dir_decoder.sv
// Receive-side step/direction decoder: counts filtered step pulses into a signed
// position, measures step period, and flags idle and direction-timing errors.
module step_dir_decoder
  import stepper_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned FILT        = FILT_DEFAULT,
  parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEFAULT,
  parameter logic        DIR_POS     = DIR_POS_DEFAULT
) (
  input logic               clock,
  input logic               reset,
  step_dir_decoder_if.slave bus
);

  localparam logic [WIDTH-1:0] IDLE_LAST = WIDTH'(IDLE_CYCLES - 1);

  logic                    dir1;
  logic                    dir_s;
  logic                    dir_q;
  logic                    rise;
  logic                    active;
  logic                    take;
  logic                    have_prev;
  logic        [WIDTH-1:0] interval;
  logic signed [WIDTH-1:0] position_q;
  logic        [WIDTH-1:0] period_q;
  logic                    step_valid_q;
  logic                    step_dir_q;
  logic                    moving_q;
  logic                    dir_err_q;

  sync_filter #(.FILT(FILT)) u_step_filter (
    .clock  (clock),
    .reset  (reset),
    .din    (bus.step_in),
    .rise   (rise),
    .active (active)
  );

  // A step landing on a clear cycle is dropped entirely, including its timing.
  assign take = rise && !bus.clear;

  always_ff @(posedge clock) begin
    if (reset) begin
      dir1         <= 1'b0;
      dir_s        <= 1'b0;
      dir_q        <= 1'b0;
      interval     <= '0;
      have_prev    <= 1'b0;
      position_q   <= '0;
      period_q     <= '0;
      step_valid_q <= 1'b0;
      step_dir_q   <= 1'b0;
      moving_q     <= 1'b0;
      dir_err_q    <= 1'b0;
    end else begin
      dir1         <= bus.dir_in;
      dir_s        <= dir1;
      dir_q        <= dir_s;
      step_valid_q <= take;

      if (take) begin
        interval <= '0;
      end else if (interval != '1) begin
        interval <= interval + 1'b1;
      end

      if (take) begin
        moving_q   <= 1'b1;
        step_dir_q <= (dir_s == DIR_POS);
      end else if (interval == IDLE_LAST) begin
        moving_q <= 1'b0;
      end

      if (bus.clear) begin
        position_q <= '0;
        period_q   <= '0;
        have_prev  <= 1'b0;
        dir_err_q  <= 1'b0;
      end else begin
        if (take) begin
          position_q <= (dir_s == DIR_POS) ? position_q + 1'b1 : position_q - 1'b1;
          have_prev  <= 1'b1;
          if (!have_prev)          period_q <= '0;
          else if (interval == '1) period_q <= '1;
          else                     period_q <= interval + 1'b1;
        end
        if (active && (dir_s != dir_q)) begin
          dir_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.position   = position_q;
  assign bus.period     = period_q;
  assign bus.step_valid = step_valid_q;
  assign bus.step_dir   = step_dir_q;
  assign bus.moving     = moving_q;
  assign bus.dir_err    = dir_err_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Testbench for step_dir_decoder: scenario tasks driving step/dir waveforms,
// checked against a debounced-edge reference model of the pin stream.
module tb_step_dir_decoder;
  import stepper_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned FILT  = 4;
  localparam int unsigned IDLE  = 20;
  localparam logic        DIRP  = 1'b1;
  localparam int          PSAT  = (1 << WIDTH) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  step_dir_decoder_if #(.WIDTH(WIDTH)) bus ();

  step_dir_decoder #(
    .WIDTH       (WIDTH),
    .FILT        (FILT),
    .IDLE_CYCLES (IDLE),
    .DIR_POS     (DIRP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: the pin stream seen two cycles late, debounced into a
  // level with hysteresis; each accepted low-to-high level change is a step.
  logic [1:0] ps = 2'b11;
  logic [1:0] pd = 2'b00;
  int         m_run = 0;
  logic       m_last = 1'b1;
  int         m_level = 2;
  int         m_pos = 0;
  logic       m_dir = 1'b0;
  int         m_period = 0;
  bit         m_have_prev = 1'b0;
  bit         m_moving = 1'b0;
  bit         m_sv = 1'b0;
  longint     m_cycle = 0;
  longint     m_last_step = 0;
  int         sv_seen = 0;

  task automatic cyc(input logic s, input logic d, input logic c);
    logic   ss, dd;
    bit     accept;
    longint diff;
    bus.step_in = s;
    bus.dir_in  = d;
    bus.clear   = c;
    @(posedge clock);
    m_cycle++;
    m_sv = 1'b0;
    if (reset) begin
      ps = 2'b11; pd = 2'b00; m_run = 0; m_last = 1'b1; m_level = 2;
      m_pos = 0; m_dir = 1'b0; m_period = 0; m_have_prev = 1'b0;
      m_moving = 1'b0; m_last_step = m_cycle;
    end else begin
      ss = ps[1];
      dd = pd[1];
      ps = {ps[0], s};
      pd = {pd[0], d};
      if (ss == m_last) begin
        if (m_run < int'(FILT)) m_run++;
      end else begin
        m_run = 1;
      end
      m_last = ss;
      accept = 1'b0;
      if (m_run == int'(FILT)) begin
        if (!ss) m_level = 0;
        else if (m_level == 0) begin
          m_level = 1;
          accept  = 1'b1;
        end
      end
      if (accept && !c) begin
        diff        = m_cycle - m_last_step;
        m_sv        = 1'b1;
        m_pos       = m_pos + ((dd == DIRP) ? 1 : -1);
        m_dir       = (dd == DIRP);
        m_period    = !m_have_prev ? 0 : ((diff > PSAT) ? PSAT : int'(diff));
        m_have_prev = 1'b1;
        m_last_step = m_cycle;
        m_moving    = 1'b1;
      end else if (m_moving && (m_cycle - m_last_step) >= IDLE) begin
        m_moving = 1'b0;
      end
      if (c) begin
        m_pos = 0; m_period = 0; m_have_prev = 1'b0;
      end
    end
    #1;
    if (bus.step_valid === 1'b1) sv_seen++;
  endtask

  // Low phase then high phase; a new direction is applied only after the step
  // line has been low for a few cycles so it never moves around a step.
  task automatic pulse(input logic d, input int lo, input int hi);
    logic old;
    old = bus.dir_in;
    for (int i = 0; i < lo; i++) cyc(1'b0, (i < 3) ? old : d, 1'b0);
    for (int i = 0; i < hi; i++) cyc(1'b1, d, 1'b0);
  endtask

  task automatic idle_low(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, bus.dir_in, 1'b0);
  endtask

  task automatic test_reset();
    int sv0;
    reset = 1'b1;
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    sv0 = sv_seen;
    repeat (20) cyc(1'b1, 1'b1, 1'b0);
    checks++;
    if (sv_seen - sv0 !== 0) begin errors++; $display("FAIL reset_arm_steps: got %0d want 0", sv_seen - sv0); end
    checks++;
    if (bus.position !== '0 || bus.period !== '0 || bus.moving !== 1'b0 || bus.dir_err !== 1'b0 || bus.step_dir !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pos=%0h per=%0h mov=%b err=%b dir=%b want all 0",
               bus.position, bus.period, bus.moving, bus.dir_err, bus.step_dir);
    end
    sv0 = sv_seen;
    repeat (3) begin
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0);
    end
    idle_low(8);
    checks++;
    if (sv_seen - sv0 !== 3) begin errors++; $display("FAIL reset_pulse_count: got %0d want 3", sv_seen - sv0); end
    checks++;
    if (bus.position !== 8'd3 || bus.position !== WIDTH'(m_pos)) begin
      errors++; $display("FAIL reset_position: got %0h want 3 (model %0h)", bus.position, WIDTH'(m_pos));
    end
    checks++;
    if (bus.period !== 8'd16 || bus.period !== WIDTH'(m_period)) begin
      errors++; $display("FAIL reset_period: got %0d want 16 (model %0d)", bus.period, m_period);
    end
  endtask

  task automatic test_latency();
    idle_low(6);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.step_valid !== (k == int'(FILT) + 1)) begin
        errors++; $display("FAIL latency_edge%0d: step_valid=%b want %b", k, bus.step_valid, (k == int'(FILT) + 1));
      end
    end
    idle_low(8);
  endtask

  task automatic test_glitch();
    logic [WIDTH-1:0] p0;
    int sv0;
    p0  = bus.position;
    sv0 = sv_seen;
    pulse(1'b1, 8, 2);
    pulse(1'b1, 2, 2);
    pulse(1'b1, 8, 5);
    pulse(1'b1, 3, 5);
    idle_low(10);
    checks++;
    if (WIDTH'(bus.position - p0) !== 8'd1 || bus.position !== WIDTH'(m_pos)) begin
      errors++; $display("FAIL glitch_delta: got %0d want 1 (model pos %0h)", WIDTH'(bus.position - p0), WIDTH'(m_pos));
    end
    checks++;
    if (sv_seen - sv0 !== 1) begin errors++; $display("FAIL glitch_pulses: got %0d want 1", sv_seen - sv0); end
  endtask

  task automatic test_direction();
    cyc(1'b0, bus.dir_in, 1'b1);
    repeat (5) pulse(1'b1, 10, 8);
    repeat (7) pulse(1'b0, 10, 8);
    idle_low(10);
    checks++;
    if (bus.position !== 8'hFE || bus.position !== WIDTH'(m_pos)) begin
      errors++; $display("FAIL dir_position: got %0h want fe (model %0h)", bus.position, WIDTH'(m_pos));
    end
    checks++;
    if (bus.step_dir !== 1'b0 || bus.step_dir !== m_dir) begin
      errors++; $display("FAIL dir_last: got %b want 0", bus.step_dir);
    end
    checks++;
    if (bus.period !== WIDTH'(m_period) || bus.dir_err !== 1'b0) begin
      errors++; $display("FAIL dir_period_err: per=%0d want %0d err=%b want 0", bus.period, m_period, bus.dir_err);
    end
  endtask

  task automatic test_wrap_clear();
    int sv0;
    cyc(1'b0, 1'b1, 1'b1);
    repeat (127) pulse(1'b1, 4, 4);
    idle_low(8);
    checks++;
    if (bus.position !== 8'h7F) begin errors++; $display("FAIL wrap_preload: got %0h want 7f", bus.position); end
    checks++;
    if (bus.period !== 8'd8) begin errors++; $display("FAIL min_period: got %0d want 8", bus.period); end
    pulse(1'b1, 4, 4);
    idle_low(8);
    checks++;
    if (bus.position !== 8'h80 || bus.position !== WIDTH'(m_pos)) begin
      errors++; $display("FAIL wrap_position: got %0h want 80", bus.position);
    end
    sv0 = sv_seen;
    for (int k = 0; k < int'(FILT) + 1; k++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.step_valid !== 1'b0 || bus.position !== '0) begin
      errors++; $display("FAIL clear_count_cycle: sv=%b pos=%0h want 0 0", bus.step_valid, bus.position);
    end
    repeat (4) cyc(1'b1, 1'b1, 1'b0);
    idle_low(8);
    checks++;
    if (sv_seen - sv0 !== 0 || bus.position !== WIDTH'(m_pos)) begin
      errors++; $display("FAIL clear_discard: pulses=%0d want 0 pos=%0h want %0h", sv_seen - sv0, bus.position, WIDTH'(m_pos));
    end
    pulse(1'b1, 4, 8);
    idle_low(8);
    checks++;
    if (bus.position !== 8'd1 || bus.period !== '0) begin
      errors++; $display("FAIL clear_first_step: pos=%0h want 1 per=%0d want 0", bus.position, bus.period);
    end
  endtask

  task automatic test_dir_err();
    int sv0;
    idle_low(10);
    sv0 = sv_seen;
    repeat (6) cyc(1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    idle_low(10);
    checks++;
    if (bus.dir_err !== 1'b1) begin errors++; $display("FAIL dir_err_set: got %b want 1", bus.dir_err); end
    checks++;
    if (sv_seen - sv0 !== 1 || bus.position !== WIDTH'(m_pos)) begin
      errors++; $display("FAIL dir_err_step: pulses=%0d want 1 pos=%0h want %0h", sv_seen - sv0, bus.position, WIDTH'(m_pos));
    end
    repeat (2) pulse(1'b0, 10, 8);
    idle_low(8);
    checks++;
    if (bus.dir_err !== 1'b1) begin errors++; $display("FAIL dir_err_sticky: got %b want 1", bus.dir_err); end
    cyc(1'b0, bus.dir_in, 1'b1);
    idle_low(2);
    checks++;
    if (bus.dir_err !== 1'b0) begin errors++; $display("FAIL dir_err_clear: got %b want 0", bus.dir_err); end
  endtask

  task automatic test_idle();
    int e, f;
    e = -1;
    f = -1;
    idle_low(30);
    for (int k = 0; k < 45; k++) begin
      cyc(k < 8, 1'b1, 1'b0);
      if (bus.step_valid === 1'b1 && e < 0) e = k;
      if (e >= 0 && f < 0 && bus.moving === 1'b0) f = k;
    end
    checks++;
    if (e < 0 || f < 0 || f - e != int'(IDLE)) begin
      errors++; $display("FAIL idle_fall: step at %0d fall at %0d, want gap %0d", e, f, IDLE);
    end
    checks++;
    if (bus.moving !== m_moving) begin errors++; $display("FAIL idle_model: moving=%b want %b", bus.moving, m_moving); end
  endtask

  task automatic test_random();
    logic d, nd;
    int   lo, hi;
    cyc(1'b0, bus.dir_in, 1'b1);
    d = bus.dir_in;
    for (int seg = 0; seg < 80; seg++) begin
      lo = int'($urandom_range(1, 12));
      hi = int'($urandom_range(1, 10));
      nd = (lo >= 10) ? 1'($urandom_range(0, 1)) : d;
      for (int i = 0; i < lo + hi; i++) begin
        cyc(i >= lo, (i < 3) ? d : nd, 1'b0);
        checks++;
        if (bus.step_valid !== m_sv || bus.position !== WIDTH'(m_pos)) begin
          errors++;
          $display("FAIL rand_cycle seg%0d: sv=%b pos=%0h want sv=%b pos=%0h", seg, bus.step_valid, bus.position, m_sv, WIDTH'(m_pos));
        end
      end
      d = nd;
    end
    idle_low(12);
    checks++;
    if (bus.period !== WIDTH'(m_period) || bus.step_dir !== m_dir || bus.moving !== m_moving) begin
      errors++;
      $display("FAIL rand_final: per=%0d dir=%b mov=%b want %0d %b %b", bus.period, bus.step_dir, bus.moving, m_period, m_dir, m_moving);
    end
    checks++;
    if (bus.dir_err !== 1'b0) begin errors++; $display("FAIL rand_dir_err: got %b want 0", bus.dir_err); end
  endtask

  initial begin
    bus.step_in = 1'b1;
    bus.dir_in  = 1'b1;
    bus.clear   = 1'b0;
    test_reset();
    test_latency();
    test_glitch();
    test_direction();
    test_wrap_clear();
    test_dir_err();
    test_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/step_dir_decoder.md
# step_dir_decoder

Receive-side decoder for the step/direction motor interface driven by the plotter's stepper outputs. It observes one axis's step and direction pins and keeps a signed position count that matches pulses actually emitted, rather than cycles spent "moving". It also measures the step period and detects idle and direction-timing errors. One instance per axis sits in the top-level wrapper, and its position feeds the regfile's currentX/currentY inputs.

## Interface
- WIDTH, 32, width of position and period outputs
- FILT, 4, consecutive equal samples required to accept a step-line level (≥2)
- IDLE_CYCLES, 1000000, cycles without a counted step before moving deasserts
- DIR_POS, 1, dir_in level meaning +1 per step
- clock  in  1  system clock (100 MHz); all logic on posedge
- reset  in  1  synchronous, active-high; clears all state
- clear  in  1  synchronous position/period/error clear (wired to centre button)
- step_in  in  1  asynchronous step pulse line
- dir_in  in  1  asynchronous direction line
- position  out  WIDTH  signed two's-complement step count; reset 0
- step_valid  out  1  one-cycle pulse per counted step; reset 0
- step_dir  out  1  direction of last counted step (1 = positive); reset 0
- period  out  WIDTH  cycles between last two counted steps; reset 0
- moving  out  1  high from a counted step until IDLE_CYCLES elapse; reset 0
- dir_err  out  1  sticky direction-timing error; reset 0

## Operation
- step_in and dir_in each pass through a 2-flop synchronizer. Only the synchronized values (step_s, dir_s) are used.
- Filter FSM states are ARM, LOW, RISE, HIGH, FALL. A run counter counts consecutive equal samples and saturates at FILT.
- ARM: entered on reset. Moves to LOW after FILT consecutive step_s=0 samples. A line already high at reset release is never counted.
- LOW → RISE on step_s=1. RISE → HIGH when the FILT-th consecutive high sample arrives. RISE → LOW on any step_s=0 sample.
- The RISE→HIGH transition counts one step:
  - step_valid pulses.
  - step_dir is set to (dir_s == DIR_POS).
  - position is incremented or decremented. It wraps modulo 2^WIDTH with no saturation.
- HIGH → FALL on step_s=0. FALL → LOW after FILT consecutive lows. FALL → HIGH on any high sample; no new step is counted.
- Interval counter:
  - Increments every cycle and saturates at all-ones.
  - On a counted step: period is loaded with interval+1, then interval is reset to 0.
  - The first step after reset or clear loads period=0. A have_prev flag tracks this.
- moving is set on a counted step. It clears when interval reaches IDLE_CYCLES−1 with no new step.
- dir_err is set when dir_s changes value while the FSM is in RISE or HIGH (direction not stable around the step). It stays set until clear or reset.
- clear:
  - Zeroes position, period, have_prev and dir_err.
  - Does not disturb the filter FSM or moving.
  - A step counted in the same cycle is discarded: no step_valid, position 0.
- reset: all registers go to their reset values; FSM goes to ARM.

## Timing
- step_in first sampled high at edge N and held: step_valid is high and position updated after edge N+2+FILT−1, i.e. N+5 for FILT=4.
- Direction is taken from dir_s at the counting edge. dir_in therefore needs setup of at least FILT+2 cycles before the step rise.
- Pulses shorter than FILT cycles high are ignored. Lows shorter than FILT cycles do not re-arm the FSM.
- Minimum countable step period is 2·FILT cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package `stepper_pkg`:
  - filter-state enum (ARM, LOW, RISE, HIGH, FALL)
  - default FILT and IDLE_CYCLES constants
  - DIR_POS encoding, shared with the stepper driver
- Sub-module `sync_filter`: 2-flop synchronizer plus run-length level filter. It outputs the filtered level and a rise-accepted pulse, and is instantiated for step_in.
- dir_in uses the synchronizer only.

## Test plan
- Reset with step_in held high, then 3 clean pulses (8 high / 8 low), dir=1 → no step during ARM; position = 3, step_valid pulses exactly 3 times, period = 16.
- 2-cycle glitches on step_in plus a 3-cycle low dropout inside a 10-cycle high pulse, FILT=4 → position changes by exactly 1.
- 5 steps with dir=1, then 7 steps with dir=0 → position = −2 (all-ones minus 1), step_dir = 0.
- Position preloaded to 0x7FFFFFFF by counting, then one positive step → 0x80000000 (wrap). clear asserted in the counting cycle → position 0, no step_valid.
- dir_in toggled while step_in is high → dir_err = 1 and stays 1 until clear. No steps for IDLE_CYCLES (set to 20) → moving falls exactly 20 cycles after the last step_valid.
